// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PC register, IF/ID stage and fetch request generation
`timescale 1ns/1ps

module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;
    logic        r_fetch_fault;
    logic [31:0] r_fetch_count;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_if_id_pc_nxt;
    logic [31:0] w_if_id_instr_nxt;
    logic        w_if_id_valid_nxt;
    logic        w_fetch_fault_nxt;
    logic [31:0] w_fetch_count_nxt;

    logic        w_req;
    logic        w_fire;
    logic        w_redirect;
    logic [31:0] w_target;

    // rst_n gates the request directly so it is low for the whole reset window
    assign w_req      = (r_state == ST_RUN) & rst_n;
    assign w_fire     = w_req & imem_ready;
    assign w_redirect = branch_taken | jump_valid;
    assign w_target   = branch_taken ? branch_target : jump_target;

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_if_id_pc_nxt    = r_if_id_pc;
        w_if_id_instr_nxt = r_if_id_instr;
        w_if_id_valid_nxt = r_if_id_valid;
        w_fetch_fault_nxt = r_fetch_fault;
        w_fetch_count_nxt = r_fetch_count;
        case (r_state)
            ST_RUN: begin
                if (w_redirect) begin
                    // Redirect wins over stall and drops whatever is being fetched
                    w_pc_nxt          = w_target;
                    w_if_id_valid_nxt = 1'b0;
                    if (w_target[1:0] != 2'b00) begin
                        w_fetch_fault_nxt = 1'b1;
                        w_state_nxt       = ST_FAULT;
                    end
                end else if (!stall) begin
                    if (w_fire) begin
                        w_pc_nxt          = r_pc + 32'd4;
                        w_if_id_pc_nxt    = r_pc;
                        w_if_id_instr_nxt = imem_rdata;
                        w_if_id_valid_nxt = 1'b1;
                        w_fetch_count_nxt = r_fetch_count + 32'd1;
                    end else begin
                        w_if_id_valid_nxt = 1'b0;
                    end
                end
            end
            ST_FAULT: begin
                w_if_id_valid_nxt = 1'b0;
                w_fetch_fault_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC_AL;
            r_if_id_pc    <= 32'd0;
            r_if_id_instr <= 32'd0;
            r_if_id_valid <= 1'b0;
            r_fetch_fault <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_if_id_pc    <= w_if_id_pc_nxt;
            r_if_id_instr <= w_if_id_instr_nxt;
            r_if_id_valid <= w_if_id_valid_nxt;
            r_fetch_fault <= w_fetch_fault_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_valid = r_if_id_valid;
    assign fetch_fault = r_fetch_fault;
    assign fetch_count = r_fetch_count;

endmodule
